bus_rx_agent: RTL and testbench
===============================

Name: bus_rx_agent

Overview:
Device-side receive stage sitting directly downstream of one device port of the shared packet bus (Top_bus). It drains that port's pending-packet interface (pndng/pop/D_pop), filters each packet on its destination-ID field and queues accepted packets in a local FIFO. The FIFO is presented to the device logic through a valid/ready interface. It also keeps accept and drop statistics.

Parameters:
PCKG_SZ, 65, packet width; bits [PCKG_SZ-1:PCKG_SZ-3] are the destination ID, the remaining bits are payload.
ID_W, 3, destination-ID width.
MY_ID, 1, this device's ID.
BROADCAST, {ID_W{1'b1}}, destination ID that every device accepts.
DEPTH, 8, local FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
bus_pndng  in  1  bus port holds at least one packet for this device.
bus_pop  out  1  pop strobe to the bus port.
bus_D_pop  in  PCKG_SZ  head packet from the bus port; valid while bus_pndng=1.
rx_valid  out  1  local FIFO is not empty.
rx_ready  in  1  device consumes the head packet.
rx_data  out  PCKG_SZ  local FIFO head packet.
rx_level  out  $clog2(DEPTH)+1  local FIFO occupancy.
accept_cnt  out  16  packets accepted; saturates at 16'hFFFF.
drop_cnt  out  16  packets discarded by the filter; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bus_pop=0; FIFO emptied.
  - rx_valid=0, rx_level=0, rx_data=0, accept_cnt=0, drop_cnt=0.
  - A packet popped but not yet written is lost. bus_pop falls immediately.
- State machine; bus_pop is a registered Moore output, high only in POP:
  - IDLE: go to POP when bus_pndng=1 and rx_level<DEPTH; otherwise stay.
  - POP: bus_pop=1. At the closing edge, sample bus_D_pop and either write it to the FIFO or drop it (filter below). Go to SETTLE.
  - SETTLE: bus_pop=0. This one-cycle gap lets the bus port update pndng/D_pop. Go to IDLE.
- Throughput and latency:
  - Maximum rate is 1 packet per 3 cycles.
  - From bus_pndng rising with IDLE and space available: bus_pop rises 1 cycle later; rx_valid rises 1 cycle after the POP edge.
- Filter: dest = bus_D_pop[PCKG_SZ-1 -: ID_W].
  - Accept if dest==MY_ID or dest==BROADCAST. Accept means write the full packet unmodified and increment accept_cnt.
  - Otherwise drop: no write, increment drop_cnt.
- Flow control: the space check happens only in IDLE. Reads only lower the level, so an in-flight accepted packet always finds space and the FIFO never overflows. With the FIFO full and bus_pndng=1, stay in IDLE with bus_pop=0.
- Local FIFO:
  - Show-ahead: rx_data is the head whenever rx_valid=1. A read occurs on rx_valid && rx_ready.
  - rx_ready with rx_valid=0 is ignored.
  - Read and write in the same cycle leave rx_level unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Counters hold at 16'hFFFF. The drop path never changes accept_cnt, and the accept path never changes drop_cnt.
- If bus_pndng falls while in POP, the sample is still taken. The bus contract forbids this, so the behaviour is don't-care.

Optional Feature:
BUS_RX_PROMISC_EN
- Defined: adds input port promisc (1 bit). When promisc=1, every popped packet is accepted regardless of dest, and drop_cnt does not increment. When promisc=0, normal filtering applies.
- Undefined: the port is absent and filtering is always active.

Test Plan:
1. Reset held low 3 cycles, then released with bus_pndng=0 -> all outputs 0, bus_pop never asserts.
2. One packet {3'b001,2'b00,{60{1'b1}}} presented with MY_ID=1 -> bus_pop high exactly 1 cycle; rx_valid=1 and rx_data equals the packet; accept_cnt=1, drop_cnt=0.
3. Packets with dest 3'b000, 3'b111, 3'b010 -> first dropped, second accepted, third dropped; accept_cnt=1, drop_cnt=2; rx_level=1.
4. 10 packets to dest 3'b001 with rx_ready=0, DEPTH=8 -> exactly 8 pops; bus_pop held 0 while rx_level=8; rx_ready=1 for 1 cycle -> level 7, the 9th pop follows; payload order preserved.
5. Continuous pndng with rx_ready=1 -> bus_pop pulses every 3rd cycle; simultaneous read/write keeps rx_level=1.
6. reset asserted during POP -> bus_pop drops asynchronously; the packet is neither written nor counted; after release the FSM restarts in IDLE. With BUS_RX_PROMISC_EN and promisc=1, dest 3'b000 is accepted and drop_cnt stays 0.

Source files
------------

// File: rtl/bus_rx_agent.sv
// Receive stage for one bus device port: pops pending packets, filters on destination ID,
// queues accepted packets in a show-ahead FIFO. Optional macro BUS_RX_PROMISC_EN adds a promisc input.
module bus_rx_agent #(
  parameter int              PCKG_SZ   = 65,
  parameter int              ID_W      = 3,
  parameter logic [ID_W-1:0] MY_ID     = ID_W'(1),
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int              DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_pndng,
  output logic                       bus_pop,
  input  logic [PCKG_SZ-1:0]         bus_D_pop,
`ifdef BUS_RX_PROMISC_EN
  input  logic                       promisc,
`endif
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [PCKG_SZ-1:0]         rx_data,
  output logic [$clog2(DEPTH):0]     rx_level,
  output logic [15:0]                accept_cnt,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  // Handshake: a read happens on a rising edge where rx_valid && rx_ready; rx_data is the
  // FIFO head while rx_valid is high and holds until that read.

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [ID_W-1:0]    dest;
  logic               accept;
  logic               do_wr;
  logic               do_drop;
  logic               do_rd;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [PCKG_SZ-1:0] mem [DEPTH];

  assign dest = bus_D_pop[PCKG_SZ-1 -: ID_W];

`ifdef BUS_RX_PROMISC_EN
  assign accept = promisc || (dest == MY_ID) || (dest == BROADCAST);
`else
  assign accept = (dest == MY_ID) || (dest == BROADCAST);
`endif

  assign do_wr     = (state == POP) && accept;
  assign do_drop   = (state == POP) && !accept;
  assign rx_valid  = (rx_level != '0);
  assign do_rd     = rx_valid && rx_ready;
  assign rx_data   = rx_valid ? mem[rd_ptr] : '0;
  assign fsm_state = state;

  // Space is only checked in IDLE; a packet in flight always fits because reads only free entries.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus_pndng && (rx_level < LW'(DEPTH))) state_next = POP;
      POP:     state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bus_pop <= 1'b0;
    end else begin
      state   <= state_next;
      bus_pop <= (state_next == POP);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus_D_pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (do_wr && (accept_cnt != 16'hFFFF))  accept_cnt <= accept_cnt + 16'd1;
      if (do_drop && (drop_cnt != 16'hFFFF))  drop_cnt   <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_bus_rx_agent.sv
// Directed bench for bus_rx_agent: bus-port model, negedge scoreboard on FIFO reads, per-test checks.
module tb_bus_rx_agent;
  localparam int PW    = 65;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          bus_pndng;
  logic          bus_pop;
  logic [PW-1:0] bus_D_pop;
  logic          rx_valid;
  logic          rx_ready;
  logic [PW-1:0] rx_data;
  logic [3:0]    rx_level;
  logic [15:0]   accept_cnt;
  logic [15:0]   drop_cnt;
  logic [1:0]    fsm_state;
`ifdef BUS_RX_PROMISC_EN
  logic          promisc;
`endif

  logic [PW-1:0] pkt_q[$];
  logic [PW-1:0] exp_q[$];
  time           pop_t[$];
  int            n_vec;
  int            n_err;
  int            pop_cnt;
  int            pop_hi;
  int            full_pop;
  int            max_lvl;

  bus_rx_agent dut (
    .clk        (clk),
    .reset      (reset),
    .bus_pndng  (bus_pndng),
    .bus_pop    (bus_pop),
    .bus_D_pop  (bus_D_pop),
`ifdef BUS_RX_PROMISC_EN
    .promisc    (promisc),
`endif
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_level   (rx_level),
    .accept_cnt (accept_cnt),
    .drop_cnt   (drop_cnt),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus port model: head stays visible until a pop strobe is seen at a rising edge
  task automatic refresh();
    bus_pndng = (pkt_q.size() != 0);
    bus_D_pop = (pkt_q.size() != 0) ? pkt_q[0] : '0;
  endtask

  always @(posedge clk) begin
    if (bus_pop) begin
      pop_cnt++;
      pop_t.push_back($time);
      #1;
      if (pkt_q.size() != 0) void'(pkt_q.pop_front());
      refresh();
    end
  end

  // scoreboard and monitors sampled on the falling edge
  always @(negedge clk) begin
    if (bus_pop) pop_hi++;
    if (bus_pop && rx_level == 4'(DEPTH)) full_pop++;
    if (int'(rx_level) > max_lvl) max_lvl = int'(rx_level);
    if (reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_read", 1, 0);
      else check("sb_data", rx_data, exp_q.pop_front());
    end
  end

  function automatic logic [PW-1:0] mk(input logic [2:0] d, input logic [61:0] pay);
    return {d, pay};
  endfunction

  // driver tasks
  task automatic push(input logic [PW-1:0] p, input bit expect_it);
    pkt_q.push_back(p);
    if (expect_it) exp_q.push_back(p);
    refresh();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx_ready = 1'b0;
    pkt_q.delete();
    exp_q.delete();
    refresh();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    pop_cnt = 0;
    pop_hi = 0;
    full_pop = 0;
    max_lvl = 0;
    pop_t.delete();
    cycles(1);
  endtask

  task automatic wait_pop(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus_pop) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    check(tag, ok, 1);
  endtask

  initial begin
    logic [PW-1:0] p1;
    n_vec = 0; n_err = 0; pop_cnt = 0; pop_hi = 0; full_pop = 0; max_lvl = 0;
    reset = 1'b0; rx_ready = 1'b0;
`ifdef BUS_RX_PROMISC_EN
    promisc = 1'b0;
`endif
    refresh();

    // 1: reset state, idle bus
    do_reset();
    cycles(4);
    check("rst_valid", rx_valid, 0);
    check("rst_level", rx_level, 0);
    check("rst_data", rx_data, 0);
    check("rst_accept", accept_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_state", fsm_state, 0);
    check("rst_no_pop", pop_hi, 0);

    // 2: single packet to MY_ID
    p1 = {3'b001, 2'b00, {60{1'b1}}};
    push(p1, 0);
    cycles(1);
    check("t2_pop_rise", bus_pop, 1);
    cycles(1);
    check("t2_valid_lat", rx_valid, 1);
    cycles(4);
    check("t2_pop_width", pop_hi, 1);
    check("t2_data", rx_data, p1);
    check("t2_accept", accept_cnt, 1);
    check("t2_drop", drop_cnt, 0);

    // 3: filter: drop 000, accept broadcast, drop 010
    do_reset();
    push(mk(3'b000, 62'h11), 0);
    push(mk(3'b111, 62'h22), 0);
    push(mk(3'b010, 62'h33), 0);
    cycles(14);
    check("t3_pops", pop_cnt, 3);
    check("t3_accept", accept_cnt, 1);
    check("t3_drop", drop_cnt, 2);
    check("t3_level", rx_level, 1);
    check("t3_data", rx_data, mk(3'b111, 62'h22));

    // 4: backpressure with a full FIFO, then ordered drain
    do_reset();
    for (int i = 0; i < 10; i++) push(mk(3'b001, 62'(i + 100)), 1);
    cycles(40);
    check("t4_pops_full", pop_cnt, 8);
    check("t4_level_full", rx_level, 8);
    check("t4_pop_low", bus_pop, 0);
    check("t4_pending", pkt_q.size(), 2);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    check("t4_level_7", rx_level, 7);
    cycles(6);
    check("t4_ninth_pop", pop_cnt, 9);
    check("t4_level_refill", rx_level, 8);
    rx_ready = 1'b1;
    cycles(60);
    rx_ready = 1'b0;
    check("t4_all_read", exp_q.size(), 0);
    check("t4_total_pops", pop_cnt, 10);
    check("t4_accept", accept_cnt, 10);
    check("t4_no_pop_full", full_pop, 0);

    // 5: simultaneous read/write, then continuous 1-in-3 rate
    do_reset();
    push(mk(3'b001, 62'hA), 1);
    wait_valid("t5_first_valid");
    push(mk(3'b001, 62'hB), 1);
    wait_pop("t5_second_pop");
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    check("t5_rw_level", rx_level, 1);
    check("t5_rw_data", rx_data, mk(3'b001, 62'hB));
    rx_ready = 1'b1;
    cycles(2);
    pop_t.delete();
    max_lvl = 0;
    for (int i = 0; i < 6; i++) push(mk(3'b001, 62'(i + 200)), 1);
    cycles(30);
    check("t5_pop_count", pop_t.size(), 6);
    for (int i = 1; i < 6 && i < pop_t.size(); i++) check("t5_pop_gap", 65'(pop_t[i] - pop_t[i-1]), 30);
    check("t5_max_level", max_lvl, 1);
    check("t5_drained", exp_q.size(), 0);
    rx_ready = 1'b0;

    // 6: reset during POP
    do_reset();
    push(mk(3'b001, 62'h55), 0);
    wait_pop("t6_pop_seen");
    #2 reset = 1'b0;
    #1;
    check("t6_async_pop", bus_pop, 0);
    check("t6_async_state", fsm_state, 0);
    pkt_q.delete();
    refresh();
    cycles(2);
    reset = 1'b1;
    pop_cnt = 0;
    cycles(5);
    check("t6_accept", accept_cnt, 0);
    check("t6_level", rx_level, 0);
    check("t6_no_pop", pop_cnt, 0);
    push(mk(3'b001, 62'h66), 0);
    cycles(6);
    check("t6_restart_accept", accept_cnt, 1);
    check("t6_restart_data", rx_data, mk(3'b001, 62'h66));
`ifdef BUS_RX_PROMISC_EN
    do_reset();
    promisc = 1'b1;
    push(mk(3'b000, 62'h77), 0);
    cycles(6);
    check("t6_promisc_accept", accept_cnt, 1);
    check("t6_promisc_drop", drop_cnt, 0);
    check("t6_promisc_data", rx_data, mk(3'b000, 62'h77));
    promisc = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
